dlfloat_mac_array: RTL and testbench
====================================

# dlfloat_mac_array

Parametrised multi-lane DLFloat16 multiply-accumulate engine with valid/ready streaming on both sides. It replaces the single free-running MAC with explicit accumulation-group control: first/last markers, a 2-stage pipeline, backpressure and a per-group beat count. It sits between the operand register wrapper and the output serialiser. Each lane accumulates Σ aᵢ·bᵢ independently over a group of beats.

## Interface
- `LANES`, 4: number of independent MAC lanes (1..8).
- `CNT_W`, 8: width of the beat counter reported per group.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand beat present.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `in_a` in 16·LANES: lane k operand A at bits [16k+15:16k], DLFloat16.
- `in_b` in 16·LANES: lane k operand B, same packing.
- `in_first` in 1: beat starts a new group; the accumulator operand is treated as 0x0000.
- `in_last` in 1: beat ends the group; the result is emitted.
- `out_valid` out 1: group result held.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `out_c` out 16·LANES: per-lane accumulated result, same packing.
- `out_count` out CNT_W: beats in the emitted group, saturating at 2^CNT_W−1.

## Operation
- **Format:** sign[15], exponent[14:9] with bias 31, mantissa[8:0] with hidden 1. Value 0x0000 is zero. Value 0xFFFF is the special NaN/Inf code.
- **Multiply:** sign = sa^sb; exp = ea+eb−31; mantissa product is 10×10 → 20 bits. If bit19 is set, take [18:10] and exp+1; otherwise take [17:9]. Truncate, no rounding. Either operand 0x0000 → 0x0000. Either operand 0xFFFF → 0xFFFF (checked first).
- **Add (accumulate):** align the smaller exponent by right shift with truncation. Same signs add; different signs subtract the smaller magnitude from the larger. Renormalise with a leading-one search over 11 bits. Result sign is the sign of the larger magnitude.
- **Add, special results:**
  - exact cancellation → 0x0000;
  - either input 0x0000 → the other input unchanged;
  - either input 0xFFFF → 0xFFFF.
- **Overflow/underflow (multiply and add):**
  - exponent > 63, or an encoding equal to 0xFFFF from arithmetic → 0xFFFF (sticky in the group);
  - exponent < 1 → 0x0000.
- **Counter:** loads 1 on a `first` beat; increments on other beats, saturating.
- **Beat without a prior `first`:** accumulates into the current register. After reset the accumulators are 0x0000.
- **`first && last` on the same beat:** single-beat group; result = product, count = 1.
- **Advance enable:** `adv = !out_valid || out_ready`. `in_ready = adv`. Both pipeline stages hold when `adv` is low.
- **Output state machine:** IDLE (`out_valid` = 0) → FULL when a stage-2 beat with `last` retires. FULL → IDLE on `out_ready` unless another `last` retires in the same cycle; in that case stay FULL with the new data.
- **Reset:** asynchronous and mid-group allowed. All state clears:
  - accumulators = 0x0000, count = 0;
  - stage valids = 0, `out_valid` = 0, `out_c` = 0, `out_count` = 0;
  - `in_ready` = 1 one cycle after deassertion.
- **In-flight data at reset:** discarded; no partial result is emitted.

## Timing
- Beat accepted at edge t: product and flags registered at t (stage 1). Accumulator updated at t+1 (stage 2).
- If the beat is `last`, `out_valid`=1 and `out_c` are visible after edge t+1. Latency is 2 cycles under no backpressure.
- Throughput is one beat per cycle while `out_ready`=1. Back-to-back groups are allowed: a `first` beat may follow a `last` beat on the next cycle.
- `out_c` and `out_count` remain stable while `out_valid && !out_ready`.
- `in_ready` is combinational from `out_valid` and `out_ready` only; there is no path from `in_valid`.

## Structure
- Package `dlfloat_pkg`:
  - constants `DLF_ZERO`=16'h0000, `DLF_SPECIAL`=16'hFFFF, `DLF_BIAS`=31, `DLF_EXP_W`=6, `DLF_MAN_W`=9;
  - pure functions `dlf_mul` and `dlf_add` implementing the rules above.
- Sub-module `dlfloat_mac_lane`: one lane holding its product register and accumulator. The top module instantiates LANES copies and owns the handshake, the counter and the output state machine.

## Test plan
- **Single-beat group:** lane0 a=0x3E00 (1.0), b=0x4000 (2.0), first=last=1 → 2 cycles later out_c lane0 = 0x4000, out_count = 1.
- **Three-beat group:** three beats of 0x3E00×0x3E00 (first on beat 1, last on beat 3) → 0x4100 (3.0), out_count = 3.
- **Cancellation and zero:** group 0x3E00×0x3E00 + 0xBE00×0x3E00 → 0x0000. Separately, a=0x0000 with any b → product 0x0000, accumulator unchanged.
- **Special code:** one beat with a=0xFFFF inside a 4-beat group → 0xFFFF. The other lanes are unaffected.
- **Backpressure:**
  - hold out_ready=0 with a result pending → in_ready=0 and out_c/out_count stable for 5 cycles;
  - release → result consumed and the next group's result follows with no loss or duplication.
- **Reset mid-group:** assert rst after 2 of 4 beats → out_valid=0 and out_c=0 immediately. A following group with a first beat 0x3E00×0x4000 and last beat → 0x4000, count 1.

Source files
------------

// File: rtl/dlfloat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dlfloat_pkg
// Brief    : DLFloat16 constants, output-state encoding and mul/add functions.
// Revision : 1.0 - initial release
// ============================================================================
package dlfloat_pkg;

    localparam logic [15:0] DLF_ZERO    = 16'h0000;
    localparam logic [15:0] DLF_SPECIAL = 16'hFFFF;
    localparam int          DLF_BIAS    = 31;
    localparam int          DLF_EXP_W   = 6;
    localparam int          DLF_MAN_W   = 9;

    typedef enum logic [0:0] {
        OUT_IDLE = 1'b0,
        OUT_FULL = 1'b1
    } out_state_t;

    // Range-check a signed biased exponent and assemble the 16-bit encoding.
    function automatic logic [15:0] dlf_pack(
        input logic              s,
        input logic signed [8:0] e,
        input logic [8:0]        m
    );
        logic [15:0] r;
        if (e > 9'sd63) begin
            r = DLF_SPECIAL;
        end else if (e < 9'sd1) begin
            r = DLF_ZERO;
        end else begin
            r = {s, e[DLF_EXP_W-1:0], m};
        end
        return r;
    endfunction

    function automatic logic [15:0] dlf_mul(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [19:0]       p;
        logic signed [8:0] e;
        logic [8:0]        m;
        logic [15:0]       r;
        p = 20'({1'b1, a[8:0]}) * 20'({1'b1, b[8:0]});
        e = $signed({3'b000, a[14:9]}) + $signed({3'b000, b[14:9]}) - 9'(DLF_BIAS);
        m = 9'(p >> (p[19] ? DLF_MAN_W + 1 : DLF_MAN_W));
        if (p[19]) begin
            e = e + 9'sd1;
        end
        if (a == DLF_SPECIAL || b == DLF_SPECIAL) begin
            r = DLF_SPECIAL;
        end else if (a == DLF_ZERO || b == DLF_ZERO) begin
            r = DLF_ZERO;
        end else begin
            r = dlf_pack(a[15] ^ b[15], e, m);
        end
        return r;
    endfunction

    function automatic logic [15:0] dlf_add(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [15:0]       hi;
        logic [15:0]       lo;
        logic [15:0]       r;
        logic [5:0]        d;
        logic [9:0]        mh;
        logic [9:0]        ms;
        logic [10:0]       s;
        logic [10:0]       sn;
        logic [3:0]        lz;
        logic signed [8:0] e;
        // Magnitude order of normal encodings matches the order of bits [14:0].
        if (a[14:0] >= b[14:0]) begin
            hi = a;
            lo = b;
        end else begin
            hi = b;
            lo = a;
        end
        d  = hi[14:9] - lo[14:9];
        mh = {1'b1, hi[8:0]};
        ms = {1'b1, lo[8:0]} >> d;
        if (hi[15] == lo[15]) begin
            s = {1'b0, mh} + {1'b0, ms};
        end else begin
            s = {1'b0, mh} - {1'b0, ms};
        end
        lz = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (s[i]) begin
                lz = 4'(i);
            end
        end
        sn = s << (4'(DLF_MAN_W + 1) - lz);
        e  = $signed({3'b000, hi[14:9]}) + $signed({5'b00000, lz}) - 9'(DLF_MAN_W);
        if (a == DLF_SPECIAL || b == DLF_SPECIAL) begin
            r = DLF_SPECIAL;
        end else if (a == DLF_ZERO) begin
            r = b;
        end else if (b == DLF_ZERO) begin
            r = a;
        end else if (hi[14:0] == lo[14:0] && hi[15] != lo[15]) begin
            r = DLF_ZERO;
        end else begin
            r = dlf_pack(hi[15], e, 9'(sn >> 1));
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dlfloat_mac_lane.sv
`default_nettype none
// ============================================================================
// Module   : dlfloat_mac_lane
// Brief    : One MAC lane: stage-1 product register and stage-2 accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module dlfloat_mac_lane
    import dlfloat_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        retire,
    input  logic        first,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    logic [15:0] r_prod;
    logic [15:0] r_acc;

    // A group-opening beat adds onto zero, which returns the product unchanged.
    assign sum = dlf_add(first ? DLF_ZERO : r_acc, r_prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod <= DLF_ZERO;
            r_acc  <= DLF_ZERO;
        end else begin
            if (load) begin
                r_prod <= dlf_mul(a, b);
            end
            if (retire) begin
                r_acc <= sum;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dlfloat_mac_array.sv
`default_nettype none
// ============================================================================
// Module   : dlfloat_mac_array
// Brief    : Multi-lane DLFloat16 MAC with first/last grouping and handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module dlfloat_mac_array
    import dlfloat_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*LANES-1:0]   in_a,
    input  logic [16*LANES-1:0]   in_b,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*LANES-1:0]   out_c,
    output logic [CNT_W-1:0]      out_count
);

    out_state_t             r_state;
    logic                   r_s1_valid;
    logic                   r_s1_first;
    logic                   r_s1_last;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_next;
    logic [16*LANES-1:0]    r_out_c;
    logic [CNT_W-1:0]       r_out_count;
    logic [16*LANES-1:0]    w_sum;
    logic                   w_adv;
    logic                   w_fire;
    logic                   w_retire;
    logic                   w_retire_last;

    // Both stages advance together whenever the output slot is free or draining.
    assign w_adv         = (r_state == OUT_IDLE) || out_ready;
    assign w_fire        = in_valid && w_adv;
    assign w_retire      = r_s1_valid && w_adv;
    assign w_retire_last = w_retire && r_s1_last;

    assign in_ready  = w_adv;
    assign out_valid = (r_state == OUT_FULL);
    assign out_c     = r_out_c;
    assign out_count = r_out_count;

    assign w_count_next = r_s1_first ? CNT_W'(1)
                        : ((&r_count) ? r_count : r_count + 1'b1);

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            dlfloat_mac_lane u_lane (
                .clk    (clk),
                .rst    (rst),
                .load   (w_fire),
                .retire (w_retire),
                .first  (r_s1_first),
                .a      (in_a[16*k +: 16]),
                .b      (in_b[16*k +: 16]),
                .sum    (w_sum[16*k +: 16])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_first <= in_first;
            r_s1_last  <= in_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= OUT_IDLE;
            r_out_c     <= '0;
            r_out_count <= '0;
        end else begin
            if (w_retire_last) begin
                r_out_c     <= w_sum;
                r_out_count <= w_count_next;
            end
            case (r_state)
                OUT_IDLE: begin
                    if (w_retire_last) begin
                        r_state <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    // A retiring group refills the slot in the cycle it drains.
                    if (!w_retire_last && out_ready) begin
                        r_state <= OUT_IDLE;
                    end
                end
                default: r_state <= OUT_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dlfloat_mac_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlfloat_mac_array
// Brief    : Directed and random stimulus against a value-level DLFloat16 model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dlfloat_mac_array;

    localparam int L  = 4;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [16*L-1:0] in_a;
    logic [16*L-1:0] in_b;
    logic            in_first;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [16*L-1:0] out_c;
    logic [CW-1:0]   out_count;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [16*L-1:0] c;
        logic [CW-1:0]   n;
    } res_t;

    res_t        exp_q[$];
    logic [15:0] m_acc[L];
    int          m_cnt;

    localparam logic [16*L-1:0] ONES  = {L{16'h3E00}};
    localparam logic [16*L-1:0] TWOS  = {L{16'h4000}};

    dlfloat_mac_array #(.LANES(L), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Value model: a number is sig * 2^k; truncate to 10 significant bits.
    function automatic logic [15:0] m_norm(input logic s, input longint n, input int k);
        longint v  = n;
        int     kk = k;
        int     be;
        if (v == 0) return 16'h0000;
        while (v >= 1024) begin v = v >> 1; kk++; end
        while (v < 512)   begin v = v << 1; kk--; end
        be = kk + 40;
        if (be > 63) return 16'hFFFF;
        if (be < 1)  return 16'h0000;
        return {s, 6'(be), 9'(v)};
    endfunction

    function automatic longint sig(input logic [15:0] x);
        return 512 + longint'(x[8:0]);
    endfunction

    function automatic int ex(input logic [15:0] x);
        return int'(x[14:9]);
    endfunction

    function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
        if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
        return m_norm(a[15] ^ b[15], sig(a) * sig(b), ex(a) + ex(b) - 80);
    endfunction

    function automatic logic [15:0] m_add(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] big;
        logic [15:0] sml;
        longint      ns;
        longint      n;
        int          sh;
        if (x == 16'hFFFF || y == 16'hFFFF) return 16'hFFFF;
        if (x == 16'h0000) return y;
        if (y == 16'h0000) return x;
        if (ex(x) > ex(y) || (ex(x) == ex(y) && sig(x) >= sig(y))) begin
            big = x; sml = y;
        end else begin
            big = y; sml = x;
        end
        sh = ex(big) - ex(sml);
        ns = (sh > 20) ? 0 : (sig(sml) >> sh);
        n  = (big[15] == sml[15]) ? sig(big) + ns : sig(big) - ns;
        if (n == 0) return 16'h0000;
        return m_norm(big[15], n, ex(big) - 40);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < L; k++) m_acc[k] = 16'h0000;
        m_cnt = 0;
    endtask

    task automatic model_beat(input logic [16*L-1:0] a, input logic [16*L-1:0] b,
                              input logic f, input logic l);
        res_t r;
        for (int k = 0; k < L; k++)
            m_acc[k] = m_add(f ? 16'h0000 : m_acc[k], m_mul(a[16*k +: 16], b[16*k +: 16]));
        m_cnt = f ? 1 : ((m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1);
        if (l) begin
            for (int k = 0; k < L; k++) r.c[16*k +: 16] = m_acc[k];
            r.n = CW'(m_cnt);
            exp_q.push_back(r);
        end
    endtask

    task automatic send(input logic [16*L-1:0] a, input logic [16*L-1:0] b,
                        input logic f, input logic l);
        int   n    = 0;
        bit   done = 1'b0;
        logic acc;
        in_a = a; in_b = b; in_first = f; in_last = l; in_valid = 1'b1;
        while (!done) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                model_beat(a, b, f, l);
                done = 1'b1;
            end else if (++n > 100) begin
                chk("send_timeout", {63'd0, in_ready}, 64'd1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [15:0] rand_op();
        int r = $urandom_range(0, 39);
        if (r == 0) return 16'h0000;
        if (r == 1) return 16'hFFFF;
        return {1'($urandom_range(0, 1)), 6'($urandom_range(26, 36)), 9'($urandom_range(0, 511))};
    endfunction

    // Each handshake on the output is matched against the model's next result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {63'd0, out_valid}, 64'd0);
            end else begin
                res_t r;
                r = exp_q.pop_front();
                chk("out_c", 64'(out_c), 64'(r.c));
                chk("out_count", 64'(out_count), 64'(r.n));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16*L-1:0] a;
        logic [16*L-1:0] b;
        int              len;
        bit              nofirst;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_c", 64'(out_c), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Single-beat group and its two-cycle latency.
        send(ONES, {{(L-1){16'h3E00}}, 16'h4000}, 1'b1, 1'b1);
        chk("lat_early_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        chk("single_c", 64'(out_c), 64'({{(L-1){16'h3E00}}, 16'h4000}));
        chk("single_count", 64'(out_count), 64'd1);

        // Three-beat group, sent back to back.
        send(ONES, ONES, 1'b1, 1'b0);
        send(ONES, ONES, 1'b0, 1'b0);
        send(ONES, ONES, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("three_c", 64'(out_c), 64'({L{16'h4100}}));
        chk("three_count", 64'(out_count), 64'd3);

        // Exact cancellation, then a zero operand leaving the sum untouched.
        send(ONES, ONES, 1'b1, 1'b0);
        send({L{16'hBE00}}, ONES, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("cancel_c", 64'(out_c), 64'd0);
        send(ONES, ONES, 1'b1, 1'b0);
        send({L{16'h0000}}, {L{16'h1234}}, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("zero_c", 64'(out_c), 64'(ONES));

        // Special code in lane 1 only.
        send(ONES, ONES, 1'b1, 1'b0);
        send(ONES, ONES, 1'b0, 1'b0);
        a = ONES;
        a[31:16] = 16'hFFFF;
        send(a, ONES, 1'b0, 1'b0);
        send(ONES, ONES, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("special_c", 64'(out_c), 64'({16'h4200, 16'h4200, 16'hFFFF, 16'h4200}));
        chk("special_count", 64'(out_count), 64'd4);
        drain();

        // Backpressure: result held, input stalled, then released.
        out_ready = 1'b0;
        send(ONES, TWOS, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        in_a = ONES; in_b = ONES; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_out_c", 64'(out_c), 64'(TWOS));
            chk("bp_out_count", 64'(out_count), 64'd1);
        end
        out_ready = 1'b1;
        send(ONES, ONES, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("bp_next_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_next_c", 64'(out_c), 64'(ONES));
        drain();

        // Reset in the middle of a four-beat group.
        send(ONES, ONES, 1'b1, 1'b0);
        send(ONES, ONES, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out_c", 64'(out_c), 64'd0);
        chk("midrst_out_count", 64'(out_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        send(ONES, TWOS, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("postrst_c", 64'(out_c), 64'(TWOS));
        chk("postrst_count", 64'(out_count), 64'd1);
        drain();

        // Accumulator clears on reset: a beat without first yields the product.
        send(ONES, ONES, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(ONES, TWOS, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("noflag_c", 64'(out_c), 64'(TWOS));
        chk("noflag_count", 64'(out_count), 64'd1);
        drain();

        // Random groups with random gaps and output stalls.
        rand_ready = 1'b1;
        for (int g = 0; g < 60; g++) begin
            len     = $urandom_range(1, 5);
            nofirst = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < len; i++) begin
                for (int k = 0; k < L; k++) begin
                    a[16*k +: 16] = rand_op();
                    b[16*k +: 16] = rand_op();
                end
                send(a, b, (i == 0) && !nofirst, i == len - 1);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
